// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared definitions for the iterative divider -- state
// encodings, handshake constants and the {remainder, quotient} result layout.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Quotient occupies the low half of the result, remainder the high half.
    localparam int QUO_LO = 0;

    function automatic int rem_hi(input int width);
        return 2 * width - 1;
    endfunction

endpackage

// File: rtl/div_clz.sv
// div_clz: WIDTH-bit leading-zero counter. An all-zero input returns WIDTH.
// Used by div_iter only when DIV_EARLY_OUT_EN is defined.
module div_clz
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the highest set bit is the last writer
    always_comb begin
        // NOTE: a default before the loop keeps every path assigned, so no latch.
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/div_iter.sv
// div_iter: multi-cycle restoring divider (signed/unsigned) for the EX stage.
// One quotient bit per BUSY cycle; result_o = {remainder, quotient}.
// Optional feature macro: DIV_EARLY_OUT_EN -- skips leading zero bits of the
// dividend magnitude so short operands finish early with identical results.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     dividend_i,
    input  logic [WIDTH-1:0]     divisor_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 div_zero_o
);

    localparam int REM_HI = rem_hi(WIDTH);

    div_state_e state_q, state_d;

    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q, dvd_q, dsr_q;
    logic               q_neg_q, r_neg_q;
    logic [2*WIDTH-1:0] result_q;
    logic               div_zero_q;

    logic               accept, divisor_zero, dividend_neg, divisor_neg, last_iter;
    logic [WIDTH-1:0]   dividend_abs, divisor_abs, dvd_load;
    logic [CNT_W-1:0]   cnt_load;
    logic [WIDTH:0]     partial, diff;
    logic               borrow;
    logic [WIDTH-1:0]   rem_nx, dvd_nx, quo_fix, rem_fix;

    // A start is taken only when idle or finishing; annul always wins.
    assign accept       = (start_i == DivStart) && !annul_i &&
                          (state_q == DIV_IDLE || state_q == DIV_DONE);
    assign divisor_zero = (divisor_i == '0);
    assign dividend_neg = signed_i & dividend_i[WIDTH-1];
    assign divisor_neg  = signed_i & divisor_i[WIDTH-1];
    assign dividend_abs = dividend_neg ? -dividend_i : dividend_i;
    assign divisor_abs  = divisor_neg  ? -divisor_i  : divisor_i;

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0] lz;

    div_clz #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_clz (
        .value (dividend_abs),
        .count (lz)
    );

    // Leading zeros would only shift zero quotient bits in; skip them.
    assign dvd_load = dividend_abs << lz;
    assign cnt_load = (lz == CNT_W'(WIDTH)) ? CNT_W'(1) : CNT_W'(WIDTH) - lz;
`else
    assign dvd_load = dividend_abs;
    assign cnt_load = CNT_W'(WIDTH);
`endif

    // One restoring step. The partial remainder is always below twice the
    // divisor, so the MSB of the (WIDTH+1)-bit difference is the borrow.
    assign last_iter = (cnt_q == CNT_W'(1));
    assign partial   = {rem_q, dvd_q[WIDTH-1]};
    assign diff      = partial - {1'b0, dsr_q};
    assign borrow    = diff[WIDTH];
    assign rem_nx    = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
    assign dvd_nx    = {dvd_q[WIDTH-2:0], ~borrow};

    // Sign fix-up: remainder follows the dividend; MIN / -1 wraps naturally.
    assign quo_fix = q_neg_q ? -dvd_nx : dvd_nx;
    assign rem_fix = r_neg_q ? -rem_nx : rem_nx;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates so every register samples pre-edge values.
        if (rst) state_q <= DIV_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (accept) state_d = divisor_zero ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: begin
                if (annul_i)        state_d = DIV_IDLE;
                else if (last_iter) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                if (accept) state_d = divisor_zero ? DIV_DONE : DIV_BUSY;
                else        state_d = DIV_IDLE;
            end
            default:        state_d = DIV_IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        busy_o  = (state_q == DIV_BUSY);
        ready_o = (state_q == DIV_DONE) ? DivResultReady : DivResultNotReady;
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else if (accept) begin
            cnt_q   <= cnt_load;
            rem_q   <= '0;
            dvd_q   <= dvd_load;
            dsr_q   <= divisor_abs;
            q_neg_q <= dividend_neg ^ divisor_neg;
            r_neg_q <= dividend_neg;
            if (divisor_zero) begin
                result_q[REM_HI -: WIDTH] <= dividend_i;
                result_q[QUO_LO +: WIDTH] <= '1;
                div_zero_q                <= 1'b1;
            end
        end else if (state_q == DIV_BUSY && !annul_i) begin
            cnt_q <= cnt_q - CNT_W'(1);
            rem_q <= rem_nx;
            dvd_q <= dvd_nx;
            if (last_iter) begin
                result_q[REM_HI -: WIDTH] <= rem_fix;
                result_q[QUO_LO +: WIDTH] <= quo_fix;
                div_zero_q                <= 1'b0;
            end
        end
    end

    assign result_o   = result_q;
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: self-checking bench for div_iter (WIDTH=32). Expected values
// come from plain integer division in a reference function.
module tb_div_iter;

    localparam int W = 32;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst, start_i, annul_i, signed_i;
    logic [W-1:0]   dividend_i, divisor_i;
    logic           busy_o, ready_o, div_zero_o;
    logic [2*W-1:0] result_o;

    int checks = 0;
    int errors = 0;

    div_iter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .result_o   (result_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Reference: integer division truncating toward zero, remainder with
    // the dividend's sign; divide by zero gives q = all ones, r = dividend.
    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, b, input logic s);
        longint na, nb, q, r;
        if (b == '0) return {a, {W{1'b1}}};
        na = s ? longint'($signed(a)) : longint'({32'b0, a});
        nb = s ? longint'($signed(b)) : longint'({32'b0, b});
        q = na / nb;
        r = na % nb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    // Cycles from accept edge to the ready cycle.
    function automatic int exp_latency(input logic [W-1:0] a, b, input logic s);
        logic [W-1:0] mag;
        int lz;
        if (b == '0) return 1;
        mag = (s && a[W-1]) ? -a : a;
        lz = 0;
        while (lz < W && mag[W-1-lz] == 1'b0) lz++;
        if (!EARLY) return W + 1;
        return ((W - lz) < 1 ? 1 : (W - lz)) + 1;
    endfunction

    // Issue one operation (called just after a negedge) and wait for ready_o.
    task automatic do_op(input logic [W-1:0] a, b, input logic s, input bit keep,
                         output int lat, output logic [2*W-1:0] res, output logic dz,
                         output bit busy_ok, output bit timed_out);
        bit done;
        dividend_i = a;
        divisor_i  = b;
        signed_i   = s;
        start_i    = 1'b1;
        lat = 0; busy_ok = 1'b1; timed_out = 1'b0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            lat++;
            if (ready_o === 1'b1) done = 1'b1;
            else begin
                if (busy_o !== 1'b1) busy_ok = 1'b0;
                if (lat >= 200) begin timed_out = 1'b1; done = 1'b1; end
            end
        end
        res = result_o;
        dz  = div_zero_o;
        if (!timed_out && busy_o !== 1'b0) busy_ok = 1'b0;
        if (!keep) start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
        dividend_i = '0; divisor_i = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++; $display("FAIL reset_flags busy=%b ready=%b expected 0 0", busy_o, ready_o);
        end
        checks++;
        if (result_o !== '0 || div_zero_o !== 1'b0) begin
            errors++; $display("FAIL reset_result got %h dz=%b expected 0 0", result_o, div_zero_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int lat; logic [2*W-1:0] res; logic dz; bit bok, to;
        do_op(32'd100, 32'd7, 1'b0, 1'b0, lat, res, dz, bok, to);
        checks++;
        if (to || res !== {32'd2, 32'd14} || dz !== 1'b0) begin
            errors++; $display("FAIL unsigned_100_7 got %h dz=%b expected %h dz=0", res, dz, {32'd2, 32'd14});
        end
        checks++;
        if (lat != exp_latency(32'd100, 32'd7, 1'b0) || !bok) begin
            errors++; $display("FAIL unsigned_latency got %0d busy_ok=%b expected %0d", lat, bok,
                               exp_latency(32'd100, 32'd7, 1'b0));
        end
    endtask

    task automatic test_signed();
        int lat; logic [2*W-1:0] res; logic dz; bit bok, to;
        do_op(-32'sd7, 32'd2, 1'b1, 1'b0, lat, res, dz, bok, to);
        checks++;
        if (to || res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || dz !== 1'b0) begin
            errors++; $display("FAIL signed_m7_2 got %h expected ffffffff_fffffffd", res);
        end
        do_op(32'd7, -32'sd2, 1'b1, 1'b0, lat, res, dz, bok, to);
        checks++;
        if (to || res !== {32'h0000_0001, 32'hFFFF_FFFD} || dz !== 1'b0) begin
            errors++; $display("FAIL signed_7_m2 got %h expected 00000001_fffffffd", res);
        end
        checks++;
        if (lat != exp_latency(32'd7, -32'sd2, 1'b1)) begin
            errors++; $display("FAIL signed_latency got %0d expected %0d", lat, exp_latency(32'd7, -32'sd2, 1'b1));
        end
    endtask

    task automatic test_min_neg1();
        int lat; logic [2*W-1:0] res; logic dz; bit bok, to;
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, lat, res, dz, bok, to);
        checks++;
        if (to || res !== {32'h0, 32'h8000_0000} || dz !== 1'b0) begin
            errors++; $display("FAIL min_neg1 got %h dz=%b expected 00000000_80000000 dz=0", res, dz);
        end
        checks++;
        if (lat != W + 1) begin
            errors++; $display("FAIL min_neg1_latency got %0d expected %0d", lat, W + 1);
        end
    endtask

    task automatic test_div_zero();
        int lat; logic [2*W-1:0] res; logic dz; bit bok, to;
        for (int m = 0; m < 2; m++) begin
            do_op(32'd5, 32'd0, m[0], 1'b0, lat, res, dz, bok, to);
            checks++;
            if (to || lat != 1 || dz !== 1'b1 || res !== {32'd5, 32'hFFFF_FFFF}) begin
                errors++; $display("FAIL div_zero mode=%0d got %h lat=%0d dz=%b expected 00000005_ffffffff lat=1 dz=1",
                                   m, res, lat, dz);
            end
        end
    endtask

    task automatic test_annul();
        int lat; logic [2*W-1:0] res; logic dz; bit bok, to, saw_ready;
        do_op(32'd100, 32'd7, 1'b0, 1'b0, lat, res, dz, bok, to);
        dividend_i = 32'hF000_0000; divisor_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
        saw_ready = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ready_o !== 1'b0) saw_ready = 1'b1;
        end
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || saw_ready) begin
            errors++; $display("FAIL annul_flags busy=%b ready=%b early_ready=%b expected 0 0 0", busy_o, ready_o, saw_ready);
        end
        checks++;
        if (result_o !== {32'd2, 32'd14}) begin
            errors++; $display("FAIL annul_hold got %h expected %h", result_o, {32'd2, 32'd14});
        end
        annul_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL annul_idle ready=%b busy=%b expected 0 0", ready_o, busy_o);
        end
        do_op(32'hF000_0000, 32'd3, 1'b0, 1'b0, lat, res, dz, bok, to);
        checks++;
        if (to || res !== ref_div(32'hF000_0000, 32'd3, 1'b0) || lat != W + 1) begin
            errors++; $display("FAIL annul_restart got %h lat=%0d expected %h lat=%0d", res, lat,
                               ref_div(32'hF000_0000, 32'd3, 1'b0), W + 1);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_ready;
        // Leave div_zero_o set so the reset visibly clears it.
        int lat; logic [2*W-1:0] res; logic dz; bit bok, to;
        do_op(32'd9, 32'd0, 1'b0, 1'b0, lat, res, dz, bok, to);
        dividend_i = 32'hF000_0000; divisor_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== '0 || div_zero_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid busy=%b ready=%b result=%h dz=%b expected all 0",
                               busy_o, ready_o, result_o, div_zero_o);
        end
        rst = 1'b0;
        saw_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0) saw_ready = 1'b1;
        end
        checks++;
        if (saw_ready) begin
            errors++; $display("FAIL reset_mid_no_ready saw ready_o=1 expected none");
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2; logic [2*W-1:0] res1, res2; logic dz1, dz2; bit bok1, bok2, to1, to2;
        do_op(32'd100, 32'd7, 1'b0, 1'b1, lat1, res1, dz1, bok1, to1);
        do_op(32'd9, 32'd3, 1'b0, 1'b0, lat2, res2, dz2, bok2, to2);
        checks++;
        if (to1 || res1 !== {32'd2, 32'd14}) begin
            errors++; $display("FAIL b2b_first got %h expected %h", res1, {32'd2, 32'd14});
        end
        checks++;
        if (to2 || res2 !== {32'd0, 32'd3} || dz2 !== 1'b0) begin
            errors++; $display("FAIL b2b_second got %h expected %h", res2, {32'd0, 32'd3});
        end
        checks++;
        if (lat2 != exp_latency(32'd9, 32'd3, 1'b0) || !bok2) begin
            errors++; $display("FAIL b2b_gap got %0d busy_ok=%b expected %0d", lat2, bok2,
                               exp_latency(32'd9, 32'd3, 1'b0));
        end
    endtask

    task automatic test_random();
        int lat; logic [2*W-1:0] res, exp_res; logic dz; bit bok, to;
        logic [W-1:0] a, b; logic s;
        for (int n = 0; n < 30; n++) begin
            a = $urandom();
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                3:       b = '1;
                default: b = $urandom();
            endcase
            s = 1'($urandom_range(0, 1));
            exp_res = ref_div(a, b, s);
            do_op(a, b, s, 1'b0, lat, res, dz, bok, to);
            checks++;
            if (to || res !== exp_res || dz !== (b == '0)) begin
                errors++; $display("FAIL rand_result a=%h b=%h s=%b got %h dz=%b expected %h dz=%b",
                                   a, b, s, res, dz, exp_res, (b == '0));
            end
            checks++;
            if (lat != exp_latency(a, b, s) || !bok) begin
                errors++; $display("FAIL rand_latency a=%h b=%h got %0d busy_ok=%b expected %0d",
                                   a, b, lat, bok, exp_latency(a, b, s));
            end
            @(negedge clk);
            checks++;
            if (ready_o !== 1'b0 || result_o !== exp_res) begin
                errors++; $display("FAIL rand_hold ready=%b result=%h expected 0 %h", ready_o, result_o, exp_res);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_min_neg1();
        test_annul();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
